// File: rtl/soc_if.sv
// Board-side signal bundle of the serial-console SoC.
// The board (master) drives the button and the serial input; the SoC (slave) drives LEDs, display and serial output.
interface soc_if #(
   parameter int DATA_W = 32
);
   logic              continue_req;
   logic              rx;
   logic              pwr;
   logic              halted;
   logic              tx;
   logic [DATA_W-1:0] debug;

   modport master (
      output continue_req, rx,
      input  pwr, halted, debug, tx
   );

   modport slave (
      input  continue_req, rx,
      output pwr, halted, debug, tx
   );
endinterface

// File: rtl/soc.sv
// Serial-console SoC: UART digits accumulate into a decimal register.
// A CR/LF halts the machine; accepted bytes are echoed back on the UART transmitter.
module soc #(
   parameter int CLKS_PER_BIT = 11,
   parameter int DATA_W       = 32
) (
   input logic   clk,
   input logic   rst,
   soc_if.slave  bus
);
   localparam int CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic {CT_RUN, CT_HALTED} ct_state_t;

   logic rx_meta_reg, rx_sync_reg;
   logic cont_meta_reg, cont_sync_reg, cont_prev_reg;
   logic pwr_reg;
   logic cont_rise;

   rx_state_t   rx_state_reg, rx_state_next;
   logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
   logic [2:0]  rx_idx_reg, rx_idx_next;
   logic [7:0]  rx_shift_reg, rx_shift_next;
   logic        rx_valid_reg, rx_valid_next;

   ct_state_t   ct_state_reg, ct_state_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic        echo_req_reg, echo_req_next;
   logic [7:0]  echo_byte_reg, echo_byte_next;

   logic        buf_full_reg, buf_full_next;
   logic [7:0]  buf_data_reg, buf_data_next;
   logic        tx_load;
   logic [7:0]  tx_load_byte;

   tx_state_t   tx_state_reg, tx_state_next;
   logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
   logic [2:0]  tx_idx_reg, tx_idx_next;
   logic [7:0]  tx_shift_reg, tx_shift_next;
   logic        tx_busy;
   logic        tx_bit;

   assign cont_rise = cont_sync_reg & ~cont_prev_reg;
   assign tx_busy   = (tx_state_reg != TX_IDLE);

   // Receiver: centre-samples each bit, starting half a bit into the start bit.
   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg + CW'(1);
      rx_idx_next   = rx_idx_reg;
      rx_shift_next = rx_shift_reg;
      rx_valid_next = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            rx_cnt_next = '0;
            if (!rx_sync_reg) rx_state_next = RX_START;
         end
         RX_START: begin
            if (rx_cnt_reg == HALF_END) begin
               rx_cnt_next   = '0;
               rx_idx_next   = '0;
               rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_reg == BIT_END) begin
               rx_cnt_next   = '0;
               rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
               rx_idx_next   = rx_idx_reg + 3'd1;
               if (rx_idx_reg == 3'd7) rx_state_next = RX_STOP;
            end
         end
         default: begin
            if (rx_cnt_reg == BIT_END) begin
               rx_cnt_next   = '0;
               rx_valid_next = rx_sync_reg;
               rx_state_next = RX_IDLE;
            end
         end
      endcase
   end

   // Control: digits accumulate in RUN; CR/LF halts; a button edge restarts from zero.
   always_comb begin
      ct_state_next  = ct_state_reg;
      acc_next       = acc_reg;
      echo_req_next  = 1'b0;
      echo_byte_next = echo_byte_reg;
      case (ct_state_reg)
         CT_RUN: begin
            if (rx_valid_reg) begin
               echo_req_next  = 1'b1;
               echo_byte_next = rx_shift_reg;
               if (rx_shift_reg >= 8'h30 && rx_shift_reg <= 8'h39)
                  acc_next = acc_reg * DATA_W'(10) + DATA_W'(rx_shift_reg[3:0]);
               else if (rx_shift_reg == 8'h0A || rx_shift_reg == 8'h0D)
                  ct_state_next = CT_HALTED;
            end
         end
         default: begin
            if (cont_rise) begin
               acc_next      = '0;
               ct_state_next = CT_RUN;
            end
         end
      endcase
   end

   // Echo holding buffer: a buffered byte always goes out before a newer one.
   always_comb begin
      buf_full_next = buf_full_reg;
      buf_data_next = buf_data_reg;
      tx_load       = 1'b0;
      tx_load_byte  = buf_data_reg;
      if (!tx_busy) begin
         if (buf_full_reg) begin
            tx_load       = 1'b1;
            buf_full_next = echo_req_reg;
            if (echo_req_reg) buf_data_next = echo_byte_reg;
         end else if (echo_req_reg) begin
            tx_load      = 1'b1;
            tx_load_byte = echo_byte_reg;
         end
      end else if (echo_req_reg && !buf_full_reg) begin
         buf_full_next = 1'b1;
         buf_data_next = echo_byte_reg;
      end
   end

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_cnt_reg + CW'(1);
      tx_idx_next   = tx_idx_reg;
      tx_shift_next = tx_shift_reg;
      case (tx_state_reg)
         TX_IDLE: begin
            tx_cnt_next = '0;
            if (tx_load) begin
               tx_shift_next = tx_load_byte;
               tx_state_next = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_reg == BIT_END) begin
               tx_cnt_next   = '0;
               tx_idx_next   = '0;
               tx_state_next = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt_reg == BIT_END) begin
               tx_cnt_next   = '0;
               tx_shift_next = {1'b0, tx_shift_reg[7:1]};
               tx_idx_next   = tx_idx_reg + 3'd1;
               if (tx_idx_reg == 3'd7) tx_state_next = TX_STOP;
            end
         end
         default: begin
            if (tx_cnt_reg == BIT_END) tx_state_next = TX_IDLE;
         end
      endcase
   end

   always_comb begin
      case (tx_state_reg)
         TX_START: tx_bit = 1'b0;
         TX_DATA:  tx_bit = tx_shift_reg[0];
         default:  tx_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_reg   <= 1'b1;
         rx_sync_reg   <= 1'b1;
         cont_meta_reg <= 1'b0;
         cont_sync_reg <= 1'b0;
         cont_prev_reg <= 1'b0;
         pwr_reg       <= 1'b0;
         rx_state_reg  <= RX_IDLE;
         rx_cnt_reg    <= '0;
         rx_idx_reg    <= '0;
         rx_shift_reg  <= '0;
         rx_valid_reg  <= 1'b0;
         ct_state_reg  <= CT_RUN;
         acc_reg       <= '0;
         echo_req_reg  <= 1'b0;
         echo_byte_reg <= '0;
         buf_full_reg  <= 1'b0;
         buf_data_reg  <= '0;
         tx_state_reg  <= TX_IDLE;
         tx_cnt_reg    <= '0;
         tx_idx_reg    <= '0;
         tx_shift_reg  <= '0;
      end else begin
         rx_meta_reg   <= bus.rx;
         rx_sync_reg   <= rx_meta_reg;
         cont_meta_reg <= bus.continue_req;
         cont_sync_reg <= cont_meta_reg;
         cont_prev_reg <= cont_sync_reg;
         pwr_reg       <= 1'b1;
         rx_state_reg  <= rx_state_next;
         rx_cnt_reg    <= rx_cnt_next;
         rx_idx_reg    <= rx_idx_next;
         rx_shift_reg  <= rx_shift_next;
         rx_valid_reg  <= rx_valid_next;
         ct_state_reg  <= ct_state_next;
         acc_reg       <= acc_next;
         echo_req_reg  <= echo_req_next;
         echo_byte_reg <= echo_byte_next;
         buf_full_reg  <= buf_full_next;
         buf_data_reg  <= buf_data_next;
         tx_state_reg  <= tx_state_next;
         tx_cnt_reg    <= tx_cnt_next;
         tx_idx_reg    <= tx_idx_next;
         tx_shift_reg  <= tx_shift_next;
      end
   end

   assign bus.pwr    = pwr_reg;
   assign bus.halted = (ct_state_reg == CT_HALTED);
   assign bus.debug  = acc_reg;
   assign bus.tx     = tx_bit;
endmodule

// File: tb/tb_soc.sv
// Bench for soc: byte-level model of the accumulator/halt/echo rules, a per-cycle compare
// process, and an independent decoder of the serial output that checks every echoed frame.
module tb_soc;
   localparam int CPB = 11;
   localparam int DW  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   soc_if #(.DATA_W(DW)) bus ();

   soc #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] m_acc    = '0;
   bit            m_halted = 1'b0;
   bit            m_pwr    = 1'b0;
   bit            model_valid = 1'b0;
   logic [7:0]    echo_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: digits accumulate mod 2^DW, CR/LF halt, halted bytes are ignored.
   task automatic model_apply(input logic [7:0] b);
      if (!m_halted) begin
         echo_q.push_back(b);
         if (b >= 8'h30 && b <= 8'h39) m_acc = m_acc * 10 + DW'(b - 8'h30);
         else if (b == 8'h0A || b == 8'h0D) m_halted = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good_stop);
      model_valid = 1'b0;
      @(negedge clk);
      bus.rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (good_stop) begin
         bus.rx = 1'b1;
         repeat (CPB) @(negedge clk);
         model_apply(b);
      end else begin
         bus.rx = 1'b0;
         repeat (CPB / 2 + 1) @(negedge clk);
         bus.rx = 1'b1;
         repeat (2 * CPB) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      model_valid = 1'b1;
      $display("rx byte %02h stop=%0b -> model debug %0d halted %0b", b, good_stop, m_acc, m_halted);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic pulse_continue();
      model_valid = 1'b0;
      @(negedge clk);
      bus.continue_req = 1'b1;
      repeat (4) @(negedge clk);
      bus.continue_req = 1'b0;
      repeat (4) @(negedge clk);
      if (m_halted) begin
         m_acc    = '0;
         m_halted = 1'b0;
      end
      model_valid = 1'b1;
      $display("continue pulse -> model debug %0d halted %0b", m_acc, m_halted);
   endtask

   task automatic do_reset(input int cycles);
      model_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset tx", bus.tx, 1);
      chk("reset pwr", bus.pwr, 0);
      chk("reset debug", bus.debug, 0);
      chk("reset halted", bus.halted, 0);
      repeat (cycles - 1) @(negedge clk);
      rst = 1'b0;
      echo_q.delete();
      m_acc    = '0;
      m_halted = 1'b0;
      m_pwr    = 1'b1;
      @(negedge clk);
      chk("post-reset pwr", bus.pwr, 1);
      chk("post-reset tx", bus.tx, 1);
      model_valid = 1'b1;
      $display("reset released");
   endtask

   // Per-cycle compare against the model while the model is settled.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("debug", bus.debug, m_acc);
         chk("halted", bus.halted, m_halted);
         chk("pwr", bus.pwr, m_pwr);
      end
   end

   // Serial-out decoder: each bit must stay constant for exactly CPB cycles.
   initial begin
      logic [9:0] bits;
      logic       first;
      bit         stable;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (!rst && bus.tx === 1'b0) begin
            aborted = 1'b0;
            stable  = 1'b1;
            bits    = '0;
            first   = 1'b0;
            for (int k = 0; k < 10; k++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (!(k == 0 && c == 0)) @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (c == 0) first = bus.tx;
                  else if (bus.tx !== first) stable = 1'b0;
                  if (c == CPB / 2) bits[k] = bus.tx;
               end
               if (aborted) break;
            end
            if (!aborted) begin
               chk("tx bit width", stable, 1);
               chk("tx stop bit", bits[9], 1);
               if (echo_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected tx frame: got byte %02h, expected no frame", bits[8:1]);
               end else begin
                  chk("echo byte", bits[8:1], echo_q.pop_front());
               end
               $display("tx frame %02h", bits[8:1]);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL timeout: got no end of test, expected completion within 600000 ns");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      int r;
      bus.rx           = 1'b1;
      bus.continue_req = 1'b0;

      do_reset(3);

      send_byte(8'h36, 1'b1);
      chk("single digit debug", bus.debug, 6);
      send_byte(8'h0A, 1'b1);
      chk("LF halted", bus.halted, 1);
      chk("LF debug frozen", bus.debug, 6);

      pulse_continue();
      chk("continue clears debug", bus.debug, 0);
      send_str("4294967296\n");
      chk("overflow debug", bus.debug, 0);
      chk("overflow halted", bus.halted, 1);
      pulse_continue();
      send_str("123\r");
      chk("123 debug", bus.debug, 123);
      chk("CR halted", bus.halted, 1);

      pulse_continue();
      send_str("7A");
      chk("non-digit keeps debug", bus.debug, 7);
      send_byte(8'h0A, 1'b1);
      send_byte(8'h35, 1'b1);
      chk("halted ignores digit", bus.debug, 7);
      pulse_continue();
      chk("continue debug", bus.debug, 0);
      chk("continue halted", bus.halted, 0);
      pulse_continue();
      chk("continue in RUN ignored", bus.halted, 0);
      send_byte(8'h35, 1'b1);
      chk("digit after continue", bus.debug, 5);

      @(negedge clk);
      bus.rx = 1'b0;
      repeat (3) @(negedge clk);
      bus.rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch ignored", bus.debug, 5);
      send_byte(8'h39, 1'b0);
      chk("framing error discarded", bus.debug, 5);

      send_byte(8'h38, 1'b1);
      repeat (20) @(negedge clk);
      do_reset(1);
      send_byte(8'h31, 1'b1);
      chk("after mid-frame reset", bus.debug, 1);

      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 99);
         if (r < 8) pulse_continue();
         r = $urandom_range(0, 99);
         if (r < 65)      b = 8'h30 + 8'($urandom_range(0, 9));
         else if (r < 70) b = 8'h0A;
         else if (r < 75) b = 8'h0D;
         else             b = 8'($urandom_range(0, 255));
         send_byte(b, $urandom_range(0, 19) != 0);
         repeat ($urandom_range(0, 15)) @(negedge clk);
      end

      repeat (400) @(negedge clk);
      chk("echo queue drained", echo_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
